bit_scan_encoder: RTL
=====================

// Module: bit_scan_encoder
// PURPOSE
//   Parametrised, clocked successor to the combinational 8-3 encoder.
//   Accepts an N-bit multi-hot word over a valid/ready handshake and emits the
//   index of every set bit, highest first, one index per beat on a second
//   valid/ready handshake. An all-zero input produces one flagged beat.
//   It sits between a request/flag register bank and any indexed consumer,
//   such as a decoder, a mux select or a display driver.
// PARAMETERS
//   N  8  input word width (N >= 2)
//   W  3  index width; must satisfy 2**W >= N
// PORTS
//   iClk    in   1  clock; all state changes on the rising edge
//   iRst    in   1  reset, asynchronous, active-high
//   iValid  in   1  input word valid
//   oReady  out  1  block can accept a word (high only in IDLE)
//   iData   in   N  input word
//   oValid  out  1  output beat valid
//   iReady  in   1  downstream accepts the beat
//   oData   out  W  index of the current highest pending set bit
//   oLast   out  1  current beat is the final beat for this word
//   oNone   out  1  the accepted word was all-zero (oData=0 on that beat)
// BEHAVIOUR
//   - States: IDLE, EMIT. The pending register is P[N-1:0].
//   - Reset (async, immediate): state=IDLE, P=0, oValid=0, oLast=0, oNone=0,
//     oData=0, oReady=1. Any word in flight is discarded.
//   - IDLE: oReady=1, oValid=0. On iValid&&oReady at an edge: P<=iData,
//     state<=EMIT, and a zero flag Z<=(iData==0).
//   - EMIT: oReady=0, oValid=1.
//     oData = index of the MSB of P. When Z=1, oData=0.
//     oLast = (P has <=1 bit set). oNone = Z.
//     oData, oLast and oNone are decoded only from registers (P, Z, state).
//     There is no combinational path from iData to any output.
//   - Beat transfer (oValid&&iReady at an edge): clear bit oData in P.
//     If oLast is set, go to IDLE and clear Z. Otherwise stay in EMIT with the
//     next lower set bit.
//   - Backpressure: while oValid&&!iReady, oData, oLast and oNone hold stable.
//   - Latency: first beat is valid on the cycle after the accept edge.
//     Throughput is 1 index/cycle while iReady=1. Minimum word period is
//     popcount+1 cycles (zero word: 2 cycles). A new word is never accepted
//     in the same cycle as the last beat.
//   - iData and iValid are ignored while oReady=0.
//   - Index arithmetic is unsigned W bits. Bits above N-1 never occur.
// CONFIGURATION
//   ENC_POPCOUNT_EN defined:
//     - Adds port oCount out, width W+1: the number of set bits in the accepted
//       word (0..N).
//     - It is registered at the accept edge and held until the next accept.
//     - Reset value is 0.
//   ENC_POPCOUNT_EN undefined: the oCount port and its logic are absent. All
//   other behaviour is identical.
// TESTING (N=8, W=3)
//   1. iRst=1 mid-clock
//      -> oValid=0, oReady=1, oData=0, oLast=0, oNone=0 immediately.
//   2. iData=8'b10100101, iReady=1
//      -> oData=7,5,2,0 on 4 consecutive cycles; oLast=1 only with 0;
//         oReady=1 on the following cycle.
//   3. One-hot walk 8'h80..8'h01, each word sent when oReady=1
//      -> one beat each, oData=7..0, oLast=1, oNone=0.
//   4. iData=8'h00
//      -> single beat oData=0, oNone=1, oLast=1; then IDLE.
//   5. iData=8'b01000001 with iReady=0 for 3 cycles
//      -> oData=6 held stable with oValid=1; after iReady=1, oData=6 then 0.
//   6. iData=8'hFF, assert iRst after the first beat
//      -> oValid=0 at once. Then iData=8'h01 -> single beat oData=0, oLast=1.
//      With ENC_POPCOUNT_EN defined: the stimulus of case 2 gives oCount=4
//      during all beats, and oCount=0 after the reset in case 6.

Source files
------------

// File: rtl/bit_scan_encoder.sv
// bit_scan_encoder: takes an N-bit multi-hot word and streams out the index of every set bit, highest first.
// Latency: first beat is valid the cycle after accept; 1 index/cycle; word period popcount+1 (zero word: 2).
// Backpressure: outputs hold while oValid && !iReady; no word is accepted outside IDLE.
// Optional feature: `define ENC_POPCOUNT_EN adds oCount, the set-bit count of the accepted word.
module bit_scan_encoder #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iValid,
    output logic         oReady,
    input  logic [N-1:0] iData,
    output logic         oValid,
    input  logic         iReady,
    output logic [W-1:0] oData,
    output logic         oLast,
    output logic         oNone
`ifdef ENC_POPCOUNT_EN
    ,
    output logic [W:0]   oCount
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t       r_state;
    logic [N-1:0] r_p;       // bits still waiting to be emitted
    logic         r_z;       // accepted word was all-zero

    logic [W-1:0] w_msb;
    logic         w_one_or_less;
    logic [N-1:0] w_clr_mask;

    // Priority scan: index of the highest pending bit (0 when nothing is pending).
    always_comb begin
        w_msb = '0;
        for (int i = 0; i < N; i++) begin
            if (r_p[i]) begin
                w_msb = W'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves zero exactly when at most one bit is set.
    assign w_one_or_less = ((r_p & (r_p - N'(1))) == '0);
    assign w_clr_mask    = N'(1) << w_msb;

    // Outputs are decoded purely from state, pending bits and the zero flag.
    assign oReady = (r_state == IDLE);
    assign oValid = (r_state == EMIT);
    assign oData  = r_z ? '0 : w_msb;
    assign oLast  = (r_state == EMIT) && w_one_or_less;
    assign oNone  = (r_state == EMIT) && r_z;

    // Accept a word in IDLE, then retire one pending bit per accepted beat.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_state <= IDLE;
            r_p     <= '0;
            r_z     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (iValid) begin
                        r_p     <= iData;
                        r_z     <= (iData == '0);
                        r_state <= EMIT;
                    end
                end
                EMIT: begin
                    if (iReady) begin
                        r_p <= r_p & ~w_clr_mask;
                        if (w_one_or_less) begin
                            r_z     <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef ENC_POPCOUNT_EN
    function automatic logic [W:0] f_popcount(input logic [N-1:0] d);
        logic [W:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + (W+1)'(d[i]);
        end
        return c;
    endfunction

    // Set-bit count captured at accept and held until the next accepted word.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oCount <= '0;
        end else if ((r_state == IDLE) && iValid) begin
            oCount <= f_popcount(iData);
        end
    end
`endif

endmodule
